// File: rtl/ram512_ctrl_pkg.sv
// rtl/ram512_ctrl_pkg.sv - shared types and constants for the ram512 Wishbone controller
//
// Contents:
//   RAM_DW        data width of the RAM macro (64)
//   RAM_SEL_W     number of byte lanes / write enables (8)
//   ctrl_state_t  controller state: CLEAR (power-on sweep) or IDLE (serving Wishbone)
//   write_mask()  per-byte write enable for a Wishbone access
package ram512_ctrl_pkg;

    localparam int RAM_DW    = 64;
    localparam int RAM_SEL_W = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } ctrl_state_t;

    // Reads present an all-zero write enable; writes pass the byte selects through.
    function automatic logic [RAM_SEL_W-1:0] write_mask(
        input logic                 we,
        input logic [RAM_SEL_W-1:0] sel
    );
        return we ? sel : {RAM_SEL_W{1'b0}};
    endfunction

endpackage

// File: rtl/ram512_clear_seq.sv
// rtl/ram512_clear_seq.sv - address sweep counter for the power-on RAM clear
//
// Only built when RAM512_WB_CTRL_CLEAR_EN is defined; the default build has
// no clear sequencer at all.
//
// Ports:
//   clk    clock, rising edge
//   rst_n  synchronous active-low reset, returns the sweep to address 0
//   busy   sweep is running; the counter advances once per cycle while high
//   addr   current word address being cleared
//   done   high during the cycle that clears the last word
`ifdef RAM512_WB_CTRL_CLEAR_EN
module ram512_clear_seq #(
    parameter int BITS = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            busy,
    output logic [BITS-1:0] addr,
    output logic            done
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (busy) begin
            // Wraps to 0 after the last word, so a later sweep starts clean.
            addr <= addr + 1'b1;
        end
    end

    assign done = busy && (addr == {BITS{1'b1}});

endmodule
`endif

// File: rtl/ram512_wb_ctrl.sv
// rtl/ram512_wb_ctrl.sv - pipelined Wishbone slave in front of a 2**BITS x 64 single-port RAM macro
//
// Optional feature: define RAM512_WB_CTRL_CLEAR_EN to zero the whole RAM after
// every reset before Wishbone traffic is accepted. Without it the RAM contents
// survive reset untouched.
//
// Ports:
//   CLK, RST_N          clock; synchronous active-low reset
//   wb_cyc, wb_stb      Wishbone pipelined cycle / strobe
//   wb_we, wb_adr       write enable, doubleword address (ADR_W bits)
//   wb_sel, wb_dat_w    byte selects and write data
//   wb_dat_r            read data, valid with wb_ack of a read, zero otherwise
//   wb_ack, wb_err      one-cycle response, one cycle after the accept
//   wb_stall            back-pressure; high in reset and while clearing
//   ram_en, ram_we      macro EN0 and per-byte WE0
//   ram_a, ram_di       macro A0 and Di0
//   ram_do              macro Do0, registered inside the macro
//   init_done           controller is serving Wishbone traffic
module ram512_wb_ctrl
    import ram512_ctrl_pkg::*;
#(
    parameter int BITS  = 9,
    parameter int ADR_W = 29
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 wb_cyc,
    input  logic                 wb_stb,
    input  logic                 wb_we,
    input  logic [ADR_W-1:0]     wb_adr,
    input  logic [RAM_SEL_W-1:0] wb_sel,
    input  logic [RAM_DW-1:0]    wb_dat_w,
    output logic [RAM_DW-1:0]    wb_dat_r,
    output logic                 wb_ack,
    output logic                 wb_err,
    output logic                 wb_stall,
    output logic                 ram_en,
    output logic [RAM_SEL_W-1:0] ram_we,
    output logic [BITS-1:0]      ram_a,
    output logic [RAM_DW-1:0]    ram_di,
    input  logic [RAM_DW-1:0]    ram_do,
    output logic                 init_done
);

    ctrl_state_t     state;
    logic            ack_q;
    logic            err_q;
    logic            rd_q;
    logic            accept;
    logic            in_range;
    logic            clearing;
    logic [BITS-1:0] clr_addr;
    logic            clr_done;

    // Reset is folded in combinationally so nothing reaches the macro, and
    // nothing is accepted, in any cycle where reset is being sampled.
    assign clearing = RST_N && (state == CLEAR);
    assign wb_stall = !RST_N || (state == CLEAR);
    assign accept   = wb_cyc && wb_stb && !wb_stall;
    assign in_range = (wb_adr >> BITS) == '0;

`ifdef RAM512_WB_CTRL_CLEAR_EN
    ram512_clear_seq #(
        .BITS (BITS)
    ) u_clear_seq (
        .clk   (CLK),
        .rst_n (RST_N),
        .busy  (clearing),
        .addr  (clr_addr),
        .done  (clr_done)
    );
`else
    assign clr_addr = '0;
    assign clr_done = 1'b0;
`endif

    // The macro port is driven in the accept cycle itself; the macro registers
    // the access, so the read data shows up on ram_do in the ack cycle.
    always_comb begin
        ram_en = 1'b0;
        ram_we = '0;
        ram_a  = '0;
        ram_di = '0;
        if (clearing) begin
            ram_en = 1'b1;
            ram_we = {RAM_SEL_W{1'b1}};
            ram_a  = clr_addr;
        end else if (accept && in_range) begin
            ram_en = 1'b1;
            ram_we = write_mask(wb_we, wb_sel);
            ram_a  = wb_adr[BITS-1:0];
            ram_di = wb_dat_w;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
`ifdef RAM512_WB_CTRL_CLEAR_EN
            state <= CLEAR;
`else
            state <= IDLE;
`endif
            init_done <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rd_q      <= 1'b0;
        end else begin
            ack_q <= accept && in_range;
            err_q <= accept && !in_range;
            rd_q  <= accept && in_range && !wb_we;
            case (state)
                CLEAR: begin
                    if (clr_done) begin
                        state     <= IDLE;
                        init_done <= 1'b1;
                    end
                end
                IDLE: begin
                    init_done <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A master that drops wb_cyc has abandoned the cycle: swallow the response.
    // Any write already issued to the macro still lands.
    assign wb_ack   = ack_q && wb_cyc && RST_N;
    assign wb_err   = err_q && wb_cyc && RST_N;
    assign wb_dat_r = (rd_q && wb_cyc && RST_N) ? ram_do : '0;

endmodule

// File: doc/ram512_wb_ctrl.md
RAM512_WB_CTRL -- requirements
Module: ram512_wb_ctrl

Interface
REQ-001 Parameter: BITS, default 9, RAM word-address width (2**BITS 64-bit words).
REQ-002 Parameter: ADR_W, default 29, Wishbone doubleword-address width, ADR_W >= BITS.
REQ-003 Port: CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: RST_N  input  1  reset, synchronous, active-low.
REQ-005 Port: wb_cyc, wb_stb, wb_we  input  1 each  Wishbone pipelined cycle, strobe, write enable.
REQ-006 Port: wb_adr  input  ADR_W  doubleword address.
REQ-007 Port: wb_sel  input  8  byte selects; wb_dat_w  input  64  write data.
REQ-008 Port: wb_dat_r  output  64  read data; wb_ack, wb_err, wb_stall  output  1 each.
REQ-009 Port: ram_en  output  1  drives the RAM macro EN0.
REQ-010 Port: ram_we  output  8  drives WE0; ram_a  output  BITS  drives A0; ram_di  output  64  drives Di0.
REQ-011 Port: ram_do  input  64  from Do0; registered in the macro, valid one cycle after ram_en, zero when ram_en was low.
REQ-012 Port: init_done  output  1  high once the controller accepts Wishbone traffic.

Function
REQ-013 A request is accepted in cycle N when wb_cyc & wb_stb & ~wb_stall.
REQ-014 Accepted in-range request (wb_adr[ADR_W-1:BITS]==0) drives, combinationally in cycle N: ram_en=1, ram_a=wb_adr[BITS-1:0], ram_di=wb_dat_w, ram_we=wb_we ? wb_sel : 8'h00.
REQ-015 No accepted request and not clearing: ram_en=0, ram_we=0, ram_a=0, ram_di=0.
REQ-016 wb_ack is registered, high in cycle N+1 for each in-range accept in cycle N; one request per cycle sustained throughput.
REQ-017 wb_dat_r = ram_do in an ack cycle of a read; 0 otherwise (including write acks).
REQ-018 Write with wb_sel==0: ram_en pulses, no bytes written, ack still returned.
REQ-019 Out-of-range accept: ram_en stays 0; wb_err high in N+1, wb_ack low.
REQ-020 wb_ack/wb_err in N+1 are suppressed if wb_cyc is low in N+1 (abandoned cycle); a RAM write issued in N still completes.
REQ-021 wb_ack and wb_err are never high together; each is a single-cycle pulse per request.
REQ-022 States: CLEAR (only with REQ-028 macro), IDLE; wb_stall=1 in CLEAR, 0 in IDLE.
REQ-023 Read-after-write to same address in consecutive cycles returns new data (macro-ordered; controller adds no forwarding).

Reset
REQ-024 RST_N low at an edge: wb_ack=0, wb_err=0, wb_dat_r=0, init_done=0, state=CLEAR (macro defined) or IDLE.
REQ-025 During RST_N low: ram_en=0, ram_we=0, wb_stall=1.
REQ-026 Reset mid-transfer: pending ack/err discarded; no ack issued for a request accepted in the cycle reset is sampled.
REQ-027 Without clear macro, init_done=1 from the first edge with RST_N high.

Configuration
REQ-028 Macro RAM512_WB_CTRL_CLEAR_EN defined: after reset, CLEAR writes 64'h0 with ram_we=8'hFF to addresses 0..2**BITS-1, one per cycle, ascending; then IDLE, init_done=1 in the cycle after the last write.
REQ-029 Macro undefined: no CLEAR state, no clear counter; RAM contents after reset are untouched (preload preserved).
REQ-030 Reset during CLEAR restarts the sweep at address 0.

Structure
REQ-031 Shared package ram512_ctrl_pkg: state enum (CLEAR, IDLE), constants RAM_DW=64, RAM_SEL_W=8.
REQ-032 Sub-module ram512_clear_seq (BITS-wide counter, busy/done) is instantiated only under the macro; all else inline.

Verification
REQ-033 Read addr 0x005 after writing 64'h0123_4567_89AB_CDEF sel 8'hFF -> ack in N+1, wb_dat_r=64'h0123_4567_89AB_CDEF.
REQ-034 Write sel 8'h0F data 64'hFFFF_FFFF_FFFF_FFFF over 64'h0 at 0x1FF, read back -> 64'h0000_0000_FFFF_FFFF.
REQ-035 Back-to-back reads 0x000..0x00F every cycle -> 16 consecutive acks, no stall, data in order.
REQ-036 wb_adr=0x200 (BITS=9) -> ram_en stays 0, wb_err pulse in N+1, no ack.
REQ-037 wb_cyc dropped in cycle after a write accept -> no ack; subsequent read of that address returns written data.
REQ-038 With RAM512_WB_CTRL_CLEAR_EN: release reset -> wb_stall high 512 cycles, init_done in cycle 513, read any address -> 0; reset at cycle 200 -> sweep restarts at 0.
